// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port arbiter sharing one registered-read single-port RAM
module mem_arbiter #(
    parameter int ADDR_LEN   = 11,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                a_req,
    input  logic [ADDR_LEN-1:0] a_addr,
    output logic                a_gnt,
    output logic                a_rvalid,
    output logic [31:0]         a_rdata,
    input  logic                b_req,
    input  logic                b_we,
    input  logic [ADDR_LEN-1:0] b_addr,
    input  logic [31:0]         b_wdata,
    output logic                b_gnt,
    output logic                b_rvalid,
    output logic [31:0]         b_rdata,
    output logic [ADDR_LEN-1:0] mem_addr,
    output logic                mem_wr_req,
    output logic [31:0]         mem_wr_data,
    input  logic [31:0]         mem_rd_data
);

    // last_gnt: 1 = port B was granted most recently
    logic last_gnt_q, last_gnt_d;
    logic rd_a_q, rd_a_d;
    logic rd_b_q, rd_b_d;

    always_comb begin
        a_gnt      = 1'b0;
        b_gnt      = 1'b0;
        last_gnt_d = last_gnt_q;
        if (a_req && b_req) begin
            if (FIXED_PRIO) begin
                b_gnt = 1'b1;
            end else if (last_gnt_q) begin
                a_gnt = 1'b1;
            end else begin
                b_gnt = 1'b1;
            end
        end else begin
            a_gnt = a_req;
            b_gnt = b_req;
        end
        if (a_gnt) begin
            last_gnt_d = 1'b0;
        end else if (b_gnt) begin
            last_gnt_d = 1'b1;
        end
        rd_a_d = a_gnt;
        rd_b_d = b_gnt & ~b_we;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt_q <= 1'b1;
            rd_a_q     <= 1'b0;
            rd_b_q     <= 1'b0;
        end else begin
            last_gnt_q <= last_gnt_d;
            rd_a_q     <= rd_a_d;
            rd_b_q     <= rd_b_d;
        end
    end

    // Idle cycles present a_addr so the RAM just performs a harmless read
    assign mem_addr    = b_gnt ? b_addr : a_addr;
    assign mem_wr_req  = b_gnt & b_we;
    assign mem_wr_data = b_wdata;

    assign a_rvalid = rd_a_q;
    assign b_rvalid = rd_b_q;
    assign a_rdata  = rd_a_q ? mem_rd_data : 32'h0;
    assign b_rdata  = rd_b_q ? mem_rd_data : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter in round-robin and fixed-priority modes
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    int          total;
    int          bad;

    logic        a_req, b_req, b_we;
    logic [10:0] a_addr, b_addr, mem_addr;
    logic [31:0] b_wdata, a_rdata, b_rdata, mem_wr_data, mem_rd_data;
    logic        a_gnt, b_gnt, a_rvalid, b_rvalid, mem_wr_req;

    logic        f_a_req, f_b_req, f_b_we;
    logic [10:0] f_a_addr, f_b_addr, f_mem_addr;
    logic [31:0] f_b_wdata, f_a_rdata, f_b_rdata, f_mem_wr_data, f_mem_rd_data;
    logic        f_a_gnt, f_b_gnt, f_a_rvalid, f_b_rvalid, f_mem_wr_req;

    logic [31:0] ram   [0:2047];
    logic [31:0] f_ram [0:2047];

    logic [31:0] qa[$], qb[$], fqa[$], fqb[$];

    mem_arbiter #(.ADDR_LEN(11), .FIXED_PRIO(1'b0)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_addr(a_addr), .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_gnt(b_gnt),
        .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_addr(mem_addr), .mem_wr_req(mem_wr_req), .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data)
    );

    mem_arbiter #(.ADDR_LEN(11), .FIXED_PRIO(1'b1)) dut_fix (
        .clk(clk), .rst(rst),
        .a_req(f_a_req), .a_addr(f_a_addr), .a_gnt(f_a_gnt), .a_rvalid(f_a_rvalid), .a_rdata(f_a_rdata),
        .b_req(f_b_req), .b_we(f_b_we), .b_addr(f_b_addr), .b_wdata(f_b_wdata), .b_gnt(f_b_gnt),
        .b_rvalid(f_b_rvalid), .b_rdata(f_b_rdata),
        .mem_addr(f_mem_addr), .mem_wr_req(f_mem_wr_req), .mem_wr_data(f_mem_wr_data),
        .mem_rd_data(f_mem_rd_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM models: write and registered read on the same edge
    always @(posedge clk) begin
        if (mem_wr_req) ram[mem_addr] <= mem_wr_data;
        mem_rd_data <= ram[mem_addr];
        if (f_mem_wr_req) f_ram[f_mem_addr] <= f_mem_wr_data;
        f_mem_rd_data <= f_ram[f_mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mon_port(input string name, input logic vld, input logic [31:0] data,
                            input int qsize, input logic [31:0] qhead, output bit popped);
        popped = 1'b0;
        if (vld) begin
            if (qsize == 0) begin
                total++;
                bad++;
                $display("FAIL %s unexpected rvalid: got data %h expected no rvalid at %0t", name, data, $time);
            end else begin
                chk(name, data, qhead);
                popped = 1'b1;
            end
        end else begin
            chk({name, "_idle"}, data, 32'h0);
        end
    endtask

    always @(negedge clk) begin
        bit p;
        mon_port("a_rdata", a_rvalid, a_rdata, qa.size(), (qa.size() != 0) ? qa[0] : 32'h0, p);
        if (p) void'(qa.pop_front());
        mon_port("b_rdata", b_rvalid, b_rdata, qb.size(), (qb.size() != 0) ? qb[0] : 32'h0, p);
        if (p) void'(qb.pop_front());
        mon_port("f_a_rdata", f_a_rvalid, f_a_rdata, fqa.size(), (fqa.size() != 0) ? fqa[0] : 32'h0, p);
        if (p) void'(fqa.pop_front());
        mon_port("f_b_rdata", f_b_rvalid, f_b_rdata, fqb.size(), (fqb.size() != 0) ? fqb[0] : 32'h0, p);
        if (p) void'(fqb.pop_front());
    end

    // One arbitration cycle: drive at edge+1, check grants at edge+4, queue expected read data
    task automatic cyc(input bit fix, input bit ar, input logic [10:0] aa,
                       input bit br, input bit bw, input logic [10:0] ba, input logic [31:0] bd,
                       input bit eag, input bit ebg, input bit push,
                       input logic [31:0] ead, input logic [31:0] ebd);
        if (!fix) begin
            a_req = ar; a_addr = aa; b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
        end else begin
            f_a_req = ar; f_a_addr = aa; f_b_req = br; f_b_we = bw; f_b_addr = ba; f_b_wdata = bd;
        end
        #3;
        if (!fix) begin
            chk("a_gnt", {31'h0, a_gnt}, {31'h0, eag});
            chk("b_gnt", {31'h0, b_gnt}, {31'h0, ebg});
            if (push && eag) qa.push_back(ead);
            if (push && ebg && !bw) qb.push_back(ebd);
        end else begin
            chk("f_a_gnt", {31'h0, f_a_gnt}, {31'h0, eag});
            chk("f_b_gnt", {31'h0, f_b_gnt}, {31'h0, ebg});
            if (push && eag) fqa.push_back(ead);
            if (push && ebg && !bw) fqb.push_back(ebd);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit fix, input int n);
        for (int i = 0; i < n; i++) cyc(fix, 0, 11'd0, 0, 0, 11'd0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        a_req = 0; a_addr = 0; b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
        f_a_req = 0; f_a_addr = 0; f_b_req = 0; f_b_we = 0; f_b_addr = 0; f_b_wdata = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_rvalid", {31'h0, a_rvalid}, 32'h0);
        chk("rst_b_rvalid", {31'h0, b_rvalid}, 32'h0);
        chk("rst_a_rdata", a_rdata, 32'h0);
        chk("rst_b_rdata", b_rdata, 32'h0);
        rst = 1'b0;

        // preload through port B
        cyc(0, 0, 11'd0, 1, 1, 11'd5, 32'hDEADBEEF, 0, 1, 0, 32'h0, 32'h0);
        cyc(0, 0, 11'd0, 1, 1, 11'd1, 32'h11111111, 0, 1, 0, 32'h0, 32'h0);
        cyc(0, 0, 11'd0, 1, 1, 11'd2, 32'h22222222, 0, 1, 0, 32'h0, 32'h0);
        cyc(0, 0, 11'd0, 1, 1, 11'd0, 32'h0BADF00D, 0, 1, 0, 32'h0, 32'h0);

        // single read
        cyc(0, 1, 11'd5, 0, 0, 11'd0, 32'h0, 1, 0, 1, 32'hDEADBEEF, 32'h0);
        idle(0, 1);

        // write then read same address next cycle
        cyc(0, 0, 11'd0, 1, 1, 11'd7, 32'h12345678, 0, 1, 0, 32'h0, 32'h0);
        cyc(0, 0, 11'd0, 1, 0, 11'd7, 32'h0, 0, 1, 1, 32'h0, 32'h12345678);
        idle(0, 1);

        // round-robin contention: last grant was B, so A first
        for (int i = 0; i < 2; i++) begin
            cyc(0, 1, 11'd1, 1, 0, 11'd2, 32'h0, 1, 0, 1, 32'h11111111, 32'h0);
            cyc(0, 1, 11'd1, 1, 0, 11'd2, 32'h0, 0, 1, 1, 32'h0, 32'h22222222);
        end
        idle(0, 1);

        // address wrap
        cyc(0, 0, 11'd0, 1, 1, 11'h7FF, 32'hA5A5A5A5, 0, 1, 0, 32'h0, 32'h0);
        cyc(0, 0, 11'd0, 1, 0, 11'h7FF, 32'h0, 0, 1, 1, 32'h0, 32'hA5A5A5A5);
        cyc(0, 0, 11'd0, 1, 0, 11'd0, 32'h0, 0, 1, 1, 32'h0, 32'h0BADF00D);
        cyc(0, 1, 11'h7FF, 0, 0, 11'd0, 32'h0, 1, 0, 1, 32'hA5A5A5A5, 32'h0);
        idle(0, 1);

        // reset with an A read in flight: it must never return
        cyc(0, 1, 11'd5, 0, 0, 11'd0, 32'h0, 1, 0, 0, 32'h0, 32'h0);
        a_req = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("midrst_a_rvalid", {31'h0, a_rvalid}, 32'h0);
        chk("midrst_b_rvalid", {31'h0, b_rvalid}, 32'h0);
        chk("midrst_a_rdata", a_rdata, 32'h0);
        chk("midrst_b_rdata", b_rdata, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(0, 1);

        // last grant was A before reset; reset value B makes A win the tie
        cyc(0, 1, 11'd1, 1, 0, 11'd2, 32'h0, 1, 0, 1, 32'h11111111, 32'h0);
        cyc(0, 1, 11'd1, 1, 0, 11'd2, 32'h0, 0, 1, 1, 32'h0, 32'h22222222);
        idle(0, 2);

        // fixed priority instance: B wins every tie
        cyc(1, 0, 11'd0, 1, 1, 11'd3, 32'hCAFE0003, 0, 1, 0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++)
            cyc(1, 1, 11'd3, 1, 1, 11'(4 + i), 32'hBEEF0004 + i, 0, 1, 0, 32'h0, 32'h0);
        cyc(1, 1, 11'd3, 0, 0, 11'd0, 32'h0, 1, 0, 1, 32'hCAFE0003, 32'h0);
        cyc(1, 1, 11'd5, 0, 0, 11'd0, 32'h0, 1, 0, 1, 32'hBEEF0005, 32'h0);
        cyc(1, 1, 11'd6, 1, 0, 11'd4, 32'h0, 0, 1, 1, 32'h0, 32'hBEEF0004);
        idle(1, 2);

        chk("qa_drained", qa.size(), 32'h0);
        chk("qb_drained", qb.size(), 32'h0);
        chk("fqa_drained", fqa.size(), 32'h0);
        chk("fqb_drained", fqb.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
